// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Segment patterns are active-high, bit0 = segment a.
package seg7_scan_capture_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {ST_WAIT, ST_HELD} dwell_state_t;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
  } scan_sample_t;

  // Bit position of a one-hot select; caller guarantees exactly one bit set.
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    onehot_idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) onehot_idx = 3'(i);
  endfunction

endpackage

// File: rtl/seg7_scan_capture_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Blank decodes to 0 as a legal digit; unknown patterns drop valid.
module seg7_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [SEG_G:SEG_A] pat,
  output logic [3:0]         nib,
  output logic               valid
);

  always_comb begin
    nib   = 4'h0;
    valid = 1'b1;
    case (pat)
      SEG_HEX_0: nib = 4'h0;
      SEG_HEX_1: nib = 4'h1;
      SEG_HEX_2: nib = 4'h2;
      SEG_HEX_3: nib = 4'h3;
      SEG_HEX_4: nib = 4'h4;
      SEG_HEX_5: nib = 4'h5;
      SEG_HEX_6: nib = 4'h6;
      SEG_HEX_7: nib = 4'h7;
      SEG_HEX_8: nib = 4'h8;
      SEG_HEX_9: nib = 4'h9;
      SEG_HEX_A: nib = 4'hA;
      SEG_HEX_B: nib = 4'hB;
      SEG_HEX_C: nib = 4'hC;
      SEG_HEX_D: nib = 4'hD;
      SEG_HEX_E: nib = 4'hE;
      SEG_HEX_F: nib = 4'hF;
      SEG_BLANK: nib = 4'h0;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a scanned 8-digit seven-segment display and rebuilds the 32-bit
// word being shown, one latch per stable digit dwell.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  i_seg,
  input  logic [7:0]  i_sel,
  input  logic        i_err_clr,
  output logic [31:0] o_value,
  output logic [7:0]  o_dp,
  output logic        o_valid,
  output logic        o_err,
  output logic [15:0] o_frame_cnt
);

  // Counter value on the cycle whose stable sample completes the dwell.
  localparam logic [7:0] LATCH_AT = 8'(STABLE_CYCLES - 2);

  scan_sample_t cur_q, prev_q;
  dwell_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         latch;

  logic [7:0][3:0] shadow_q, nib_merged;
  logic [7:0]      shadow_dp_q, dp_merged;
  logic [7:0]      seen_q;

  logic       stable, sel_onehot, sel_multi;
  logic [2:0] idx;
  logic [3:0] dec_nib;
  logic       dec_ok;
  logic       wr, frame_done, err_set;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= '{sel: ~i_sel, seg: ~i_seg};
      prev_q <= cur_q;
    end
  end

  assign stable     = (cur_q == prev_q);
  assign sel_onehot = (cur_q.sel != 8'h00) && ((cur_q.sel & (cur_q.sel - 8'h01)) == 8'h00);
  assign sel_multi  = (cur_q.sel != 8'h00) && !sel_onehot;
  assign idx        = onehot_idx(cur_q.sel);

  seg7_decode u_decode (
    .pat   (cur_q.seg[SEG_G:0]),
    .nib   (dec_nib),
    .valid (dec_ok)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Idle or multi-hot select never accumulates dwell; HELD saturates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!stable || !sel_onehot) begin
          cnt_d = 8'h00;
        end else if (cnt_q == LATCH_AT) begin
          latch   = 1'b1;
          state_d = ST_HELD;
          cnt_d   = cnt_q + 8'h01;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      ST_HELD: begin
        if (!stable) begin
          state_d = ST_WAIT;
          cnt_d   = 8'h00;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = 8'h00;
      end
    endcase
  end

  always_comb begin
    nib_merged      = shadow_q;
    nib_merged[idx] = dec_nib;
    dp_merged       = shadow_dp_q;
    dp_merged[idx]  = cur_q.seg[SEG_DP];
  end

  assign wr         = latch && dec_ok;
  assign frame_done = wr && ((seen_q | cur_q.sel) == 8'hFF);
  assign err_set    = sel_multi || (latch && !dec_ok);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      seen_q      <= '0;
      o_value     <= '0;
      o_dp        <= '0;
      o_valid     <= 1'b0;
      o_frame_cnt <= '0;
      o_err       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= (o_err && !i_err_clr) || err_set;
      if (wr) begin
        shadow_q    <= nib_merged;
        shadow_dp_q <= dp_merged;
        if (frame_done) begin
          o_value     <= nib_merged;
          o_dp        <= dp_merged;
          o_valid     <= 1'b1;
          seen_q      <= '0;
          o_frame_cnt <= o_frame_cnt + 16'h0001;
        end else begin
          seen_q <= seen_q | cur_q.sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: expected frames are queued when the
// completing digit is driven and checked whenever o_valid is seen.
module tb_seg7_scan_capture;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  i_seg, i_sel;
  logic        i_err_clr;
  logic [31:0] o_value;
  logic [7:0]  o_dp;
  logic        o_valid, o_err;
  logic [15:0] o_frame_cnt;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   valid_cnt  = 0;

  seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .i_seg       (i_seg),
    .i_sel       (i_sel),
    .i_err_clr   (i_err_clr),
    .o_value     (o_value),
    .o_dp        (o_dp),
    .o_valid     (o_valid),
    .o_err       (o_err),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: hexpat = 7'h3F; 4'h1: hexpat = 7'h06; 4'h2: hexpat = 7'h5B; 4'h3: hexpat = 7'h4F;
      4'h4: hexpat = 7'h66; 4'h5: hexpat = 7'h6D; 4'h6: hexpat = 7'h7D; 4'h7: hexpat = 7'h07;
      4'h8: hexpat = 7'h7F; 4'h9: hexpat = 7'h6F; 4'hA: hexpat = 7'h77; 4'hB: hexpat = 7'h7C;
      4'hC: hexpat = 7'h39; 4'hD: hexpat = 7'h5E; 4'hE: hexpat = 7'h79; default: hexpat = 7'h71;
    endcase
  endfunction

  // Scoreboard consumer: every o_valid must match a queued frame.
  always @(negedge clk_in) begin
    if (reset === 1'b0 && o_valid === 1'b1) begin
      valid_cnt++;
      chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_value", o_value, e.value);
        chk("frame_dp", {24'h0, o_dp}, {24'h0, e.dp});
      end
    end
  end

  task automatic idle();
    i_sel = 8'hFF;
    i_seg = 8'hFF;
  endtask

  task automatic send_raw(input logic [7:0] sel_n, input logic [7:0] seg_n, input int n);
    i_sel = sel_n;
    i_seg = seg_n;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_digit(input int idx, input logic [6:0] pat, input logic dp, input int n);
    send_raw(~(8'h01 << idx), ~{dp, pat}, n);
  endtask

  task automatic drive_digits(input logic [31:0] val, input logic [7:0] dp,
                              input logic [7:0] blank, input logic [7:0] mask);
    for (int i = 0; i < 8; i++)
      if (mask[i])
        send_digit(i, blank[i] ? 7'h00 : hexpat(val[i*4 +: 4]), dp[i], 4);
    idle();
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    int vc;
    reset     = 1'b1;
    i_err_clr = 1'b0;
    idle();
    repeat (2) @(negedge clk_in);
    chk("rst_value", o_value, 32'h0);
    chk("rst_dp", {24'h0, o_dp}, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_err", {31'h0, o_err}, 32'h0);
    chk("rst_frame_cnt", {16'h0, o_frame_cnt}, 32'h0);
    reset = 1'b0;
    @(negedge clk_in);

    // Full frame 8..1 on digits 0..7, with latency of the completing digit.
    exp_q.push_back('{value: 32'h12345678, dp: 8'h00});
    drive_digits(32'h12345678, 8'h00, 8'h00, 8'hFF);
    chk("lat_valid_early", {31'h0, o_valid}, 32'h0);
    @(negedge clk_in);
    chk("lat_valid_on", {31'h0, o_valid}, 32'h1);
    @(negedge clk_in);
    chk("lat_valid_pulse", {31'h0, o_valid}, 32'h0);
    settle();
    chk("full_frame_cnt", {16'h0, o_frame_cnt}, 32'd1);
    chk("full_err", {31'h0, o_err}, 32'h0);
    chk("full_valid_cnt", valid_cnt, 32'd1);

    // Short-dwell glitch on the completing digit must not latch.
    drive_digits(32'h76549210, 8'h00, 8'h00, 8'hF7);
    send_digit(3, hexpat(4'hE), 1'b0, 3);
    exp_q.push_back('{value: 32'h76549210, dp: 8'h00});
    send_digit(3, hexpat(4'h9), 1'b0, 4);
    idle();
    settle();
    chk("glitch_frame_cnt", {16'h0, o_frame_cnt}, 32'd2);
    chk("glitch_err", {31'h0, o_err}, 32'h0);

    // Undecodable pattern on digit 2 blocks completion until re-sent.
    vc = valid_cnt;
    drive_digits(32'h10FEDCBA, 8'h00, 8'h00, 8'h03);
    send_raw(~8'h04, 8'hFE, 4);
    drive_digits(32'h10FEDCBA, 8'h00, 8'h00, 8'hF8);
    settle();
    chk("bad_seg_err", {31'h0, o_err}, 32'h1);
    chk("bad_seg_no_frame", valid_cnt, vc);
    chk("bad_seg_frame_cnt", {16'h0, o_frame_cnt}, 32'd2);
    exp_q.push_back('{value: 32'h10FEDCBA, dp: 8'h00});
    drive_digits(32'h10FEDCBA, 8'h00, 8'h00, 8'h04);
    settle();
    chk("resend_frame_cnt", {16'h0, o_frame_cnt}, 32'd3);
    i_err_clr = 1'b1;
    @(negedge clk_in);
    i_err_clr = 1'b0;
    @(negedge clk_in);
    chk("err_clr", {31'h0, o_err}, 32'h0);

    // Multi-hot select covering slot 0 must not complete a frame missing slot 0.
    vc = valid_cnt;
    drive_digits(32'h2468ACE1, 8'h00, 8'h00, 8'hFE);
    send_raw(8'hFC, ~{1'b0, hexpat(4'h1)}, 5);
    idle();
    settle();
    chk("multi_err", {31'h0, o_err}, 32'h1);
    chk("multi_no_frame", valid_cnt, vc);
    i_err_clr = 1'b1;
    @(negedge clk_in);
    i_err_clr = 1'b0;
    @(negedge clk_in);
    chk("multi_err_clr", {31'h0, o_err}, 32'h0);
    i_sel = 8'hFC;
    @(negedge clk_in);
    i_err_clr = 1'b1;
    @(negedge clk_in);
    chk("set_beats_clr", {31'h0, o_err}, 32'h1);
    i_err_clr = 1'b0;
    idle();
    @(negedge clk_in);
    exp_q.push_back('{value: 32'h2468ACE1, dp: 8'h00});
    drive_digits(32'h2468ACE1, 8'h00, 8'h00, 8'h01);
    settle();
    chk("multi_frame_cnt", {16'h0, o_frame_cnt}, 32'd4);

    // Asynchronous reset mid-frame clears outputs before the next edge.
    drive_digits(32'h55555555, 8'h00, 8'h00, 8'h1F);
    #2 reset = 1'b1;
    #1;
    chk("amid_value", o_value, 32'h0);
    chk("amid_frame_cnt", {16'h0, o_frame_cnt}, 32'h0);
    chk("amid_err", {31'h0, o_err}, 32'h0);
    chk("amid_dp", {24'h0, o_dp}, 32'h0);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    exp_q.push_back('{value: 32'h00FEDCBA, dp: 8'h00});
    drive_digits(32'h00FEDCBA, 8'h00, 8'h80, 8'hFF);
    settle();
    chk("post_rst_frame_cnt", {16'h0, o_frame_cnt}, 32'd1);

    // Decimal point on the most significant digit.
    exp_q.push_back('{value: 32'h87654321, dp: 8'h80});
    drive_digits(32'h87654321, 8'h80, 8'h00, 8'hFF);
    settle();
    chk("dp_frame_cnt", {16'h0, o_frame_cnt}, 32'd2);
    chk("dp_err", {31'h0, o_err}, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
